// File: rtl/ssd_capture.sv
// Receiving end of the multiplexed seven-segment bus: filters scan transitions
// and rebuilds the per-digit hex value, decimal point and validity, flagging illegal bus states.
module ssd_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        ssd_capture_port_clk,
    input  logic        ssd_capture_port_rst,
    input  logic [6:0]  ssd_capture_port_cc,
    input  logic        ssd_capture_port_dp,
    input  logic [7:0]  ssd_capture_port_an,
    input  logic        ssd_capture_port_clr,
    output logic [31:0] ssd_capture_port_hex,
    output logic [7:0]  ssd_capture_port_dpo,
    output logic [7:0]  ssd_capture_port_vld,
    output logic        ssd_capture_port_upd,
    output logic        ssd_capture_port_err,
    output logic [1:0]  ssd_capture_port_ecode,
    output logic [2:0]  ssd_capture_port_eidx
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    localparam logic [1:0] ECODE_NONE  = 2'b00;
    localparam logic [1:0] ECODE_SEG   = 2'b01;
    localparam logic [1:0] ECODE_MULTI = 2'b10;
    localparam logic [6:0] CC_BLANK    = 7'h7F;

    // Returns {match, nibble}; match is 0 for anything outside the 16 glyphs.
    function automatic logic [4:0] seg_decode(input logic [6:0] cc);
        case (cc)
            7'h40:   seg_decode = {1'b1, 4'h0};
            7'h79:   seg_decode = {1'b1, 4'h1};
            7'h24:   seg_decode = {1'b1, 4'h2};
            7'h30:   seg_decode = {1'b1, 4'h3};
            7'h19:   seg_decode = {1'b1, 4'h4};
            7'h12:   seg_decode = {1'b1, 4'h5};
            7'h02:   seg_decode = {1'b1, 4'h6};
            7'h78:   seg_decode = {1'b1, 4'h7};
            7'h00:   seg_decode = {1'b1, 4'h8};
            7'h10:   seg_decode = {1'b1, 4'h9};
            7'h08:   seg_decode = {1'b1, 4'hA};
            7'h03:   seg_decode = {1'b1, 4'hB};
            7'h46:   seg_decode = {1'b1, 4'hC};
            7'h21:   seg_decode = {1'b1, 4'hD};
            7'h06:   seg_decode = {1'b1, 4'hE};
            7'h0E:   seg_decode = {1'b1, 4'hF};
            default: seg_decode = 5'b00000;
        endcase
    endfunction

    function automatic logic [3:0] count_low(input logic [7:0] an);
        count_low = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count_low = count_low + {3'b000, ~an[i]};
        end
    endfunction

    // Only meaningful when exactly one anode is low.
    function automatic logic [2:0] low_index(input logic [7:0] an);
        low_index = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an[i]) begin
                low_index = 3'(i);
            end else begin
                low_index = low_index;
            end
        end
    endfunction

    logic [6:0]    s_cc_r;
    logic          s_dp_r;
    logic [7:0]    s_an_r;
    logic [CW-1:0] cnt_r;
    logic [31:0]   hex_r;
    logic [7:0]    dpo_r;
    logic [7:0]    vld_r;
    logic          upd_r;
    logic          err_r;
    logic [1:0]    ecode_r;
    logic [2:0]    eidx_r;

    logic          same_s;
    logic          commit_s;
    logic [CW-1:0] cnt_s;
    logic [4:0]    dec_s;
    logic [3:0]    nlow_s;
    logic [2:0]    idx_s;
    logic [31:0]   hex_s;
    logic [7:0]    dpo_s;
    logic [7:0]    vld_s;
    logic          upd_s;
    logic          err_s;
    logic [1:0]    ecode_s;
    logic [2:0]    eidx_s;

    assign dec_s  = seg_decode(ssd_capture_port_cc);
    assign nlow_s = count_low(ssd_capture_port_an);
    assign idx_s  = low_index(ssd_capture_port_an);

    // Stability filter: count identical samples, commit once per stable period.
    always_comb begin
        same_s = (ssd_capture_port_cc == s_cc_r) &&
                 (ssd_capture_port_dp == s_dp_r) &&
                 (ssd_capture_port_an == s_an_r);
        commit_s = same_s && (cnt_r == CNT_LAST);
        if (!same_s) begin
            cnt_s = {CW{1'b0}};
        end else if (cnt_r == CNT_MAX) begin
            cnt_s = cnt_r;
        end else begin
            cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Next digit/error state: clear first, then the commit on top of it.
    always_comb begin
        hex_s   = hex_r;
        dpo_s   = dpo_r;
        vld_s   = vld_r;
        upd_s   = 1'b0;
        err_s   = err_r;
        ecode_s = ecode_r;
        eidx_s  = eidx_r;
        if (ssd_capture_port_clr) begin
            err_s   = 1'b0;
            ecode_s = ECODE_NONE;
            eidx_s  = 3'd0;
            vld_s   = 8'h00;
        end else begin
            vld_s   = vld_r;
        end
        if (commit_s && (nlow_s != 4'd0)) begin
            upd_s = 1'b1;
            if (nlow_s == 4'd1) begin
                if (dec_s[4]) begin
                    hex_s[{idx_s, 2'b00} +: 4] = dec_s[3:0];
                    vld_s[idx_s] = 1'b1;
                    dpo_s[idx_s] = ~ssd_capture_port_dp;
                end else if (ssd_capture_port_cc == CC_BLANK) begin
                    vld_s[idx_s] = 1'b0;
                    dpo_s[idx_s] = ~ssd_capture_port_dp;
                end else begin
                    vld_s[idx_s] = 1'b0;
                    if (!err_s) begin
                        ecode_s = ECODE_SEG;
                        eidx_s  = idx_s;
                    end else begin
                        ecode_s = ecode_s;
                    end
                    err_s = 1'b1;
                end
            end else begin
                if (!err_s) begin
                    ecode_s = ECODE_MULTI;
                    eidx_s  = 3'd0;
                end else begin
                    ecode_s = ecode_s;
                end
                err_s = 1'b1;
            end
        end else begin
            upd_s = 1'b0;
        end
    end

    // State registers; idle-bus sample values so a held idle bus never commits a digit.
    always_ff @(posedge ssd_capture_port_clk or posedge ssd_capture_port_rst) begin
        if (ssd_capture_port_rst) begin
            s_cc_r  <= CC_BLANK;
            s_dp_r  <= 1'b1;
            s_an_r  <= 8'hFF;
            cnt_r   <= {CW{1'b0}};
            hex_r   <= 32'h0000_0000;
            dpo_r   <= 8'h00;
            vld_r   <= 8'h00;
            upd_r   <= 1'b0;
            err_r   <= 1'b0;
            ecode_r <= ECODE_NONE;
            eidx_r  <= 3'd0;
        end else begin
            s_cc_r  <= ssd_capture_port_cc;
            s_dp_r  <= ssd_capture_port_dp;
            s_an_r  <= ssd_capture_port_an;
            cnt_r   <= cnt_s;
            hex_r   <= hex_s;
            dpo_r   <= dpo_s;
            vld_r   <= vld_s;
            upd_r   <= upd_s;
            err_r   <= err_s;
            ecode_r <= ecode_s;
            eidx_r  <= eidx_s;
        end
    end

    assign ssd_capture_port_hex   = hex_r;
    assign ssd_capture_port_dpo   = dpo_r;
    assign ssd_capture_port_vld   = vld_r;
    assign ssd_capture_port_upd   = upd_r;
    assign ssd_capture_port_err   = err_r;
    assign ssd_capture_port_ecode = ecode_r;
    assign ssd_capture_port_eidx  = eidx_r;

endmodule

// File: doc/ssd_capture.md
# ssd_capture

Capture/decode block for the multiplexed seven-segment bus: samples the active-low cathode, decimal-point and anode lines that `ssd_driver` produces and reconstructs the hex value, decimal point and validity of each of the 8 digit positions. It is the receiving end of the `ssd_driver` interface. It serves as a self-checking monitor in benches and as an on-chip loopback checker behind the display driver. A stability filter rejects scan transitions and ghosting, and illegal bus states are flagged.

## Interface
- `STABLE_CYCLES`, default 4, consecutive identical samples required before a commit; legal values ≥ 1.
- `ssd_capture_port_clk` in 1: the single clock, rising edge.
- `ssd_capture_port_rst` in 1: reset, asynchronous, active-high.
- `ssd_capture_port_cc` in 7: cathodes, active-low; bit 0 = a … bit 6 = g.
- `ssd_capture_port_dp` in 1: decimal point, active-low.
- `ssd_capture_port_an` in 8: anodes, active-low; bit i selects digit i.
- `ssd_capture_port_clr` in 1: synchronous clear of error state and all valid flags.
- `ssd_capture_port_hex` out 32: digit i nibble at [4i+3:4i].
- `ssd_capture_port_dpo` out 8: decimal point lit for digit i, active-high.
- `ssd_capture_port_vld` out 8: digit i holds a decoded value.
- `ssd_capture_port_upd` out 1: one-cycle pulse on every commit.
- `ssd_capture_port_err` out 1: sticky error flag.
- `ssd_capture_port_ecode` out 2: error code of the first error. 00 = none, 01 = bad segment pattern, 10 = multiple anodes.
- `ssd_capture_port_eidx` out 3: digit index of the first bad-pattern error; 0 for a multi-anode error.

## Operation
- **Sample registers.** The block holds sample registers s_cc, s_dp and s_an. They load the inputs on every edge.
- **Stability counter.** Each edge, compare the inputs with the s_* registers:
  - If equal, cnt increments, saturating at STABLE_CYCLES.
  - If different, cnt is cleared to 0.
- **Commit.** A commit occurs on the edge where the inputs equal s_* and cnt = STABLE_CYCLES−1. It fires once per stable period; saturation prevents repeats.
- **Commit classification.** Each commit is classified on the anode value:
  - an = 8'hFF: no digit is selected. The commit is ignored: no upd and no state change.
  - Exactly one bit of an low (digit i):
    - Decode cc with the table below. On a match: hex[i] ← value, vld[i] ← 1, dpo[i] ← ~dp.
    - cc = 7'h7F (blank): vld[i] ← 0, dpo[i] ← ~dp, hex[i] unchanged.
    - Any other cc: vld[i] ← 0 and a bad-pattern error is raised with eidx = i.
  - Two or more bits of an low: a multi-anode error is raised; no digit state changes.
  - upd pulses on every non-ignored commit, including blank and error commits.
- **Decode table** (cc value → digit):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F
- **Error handling.**
  - Raising an error sets err = 1.
  - ecode and eidx are written only while err = 0, so the first error is retained.
- **Clear.**
  - clr clears err, ecode, eidx and all vld bits.
  - A commit on the same edge is applied after the clear. The committing digit's vld, and any new error, reflect that commit.

## Timing
- **Reset values.**
  - Outputs: hex = 0, dpo = 0, vld = 0, upd = 0, err = 0, ecode = 0, eidx = 0.
  - Internal: cnt = 0, s_cc = 7'h7F, s_dp = 1, s_an = 8'hFF.
- **Reset behaviour.** Reset acts immediately (asynchronous) and aborts any count in progress. After release, the bus must be stable for STABLE_CYCLES+1 edges before a commit.
- **Commit latency.** Let edge 0 be the first edge seeing a new input value, with the value then held. The commit happens on edge STABLE_CYCLES. hex, vld, dpo and err change after that edge, and upd is high for the following cycle only.
- **Glitch rejection.** A value held for fewer than STABLE_CYCLES+1 edges never commits.
- **Latency bound.** Commit latency is fixed; there is no backpressure.

## Test plan
- **Reset:** rst high mid-operation → all outputs 0 immediately; after release, hold an=FE, cc=40 → commit on edge STABLE_CYCLES, not earlier.
- **Single digit:** an=FE, cc=40, dp=1 held 10 cycles (STABLE_CYCLES=4) → hex[3:0]=0, vld=8'h01, dpo=0, exactly one upd pulse, at edge 4.
- **Full decode sweep:** an=F7, dp=0, cc stepping through all 16 table codes, each held 6 cycles → hex[15:12] = 0..F in turn, dpo[3]=1, vld[3]=1, 16 upd pulses.
- **Glitch and blank:**
  - Value held only 3 edges → no upd, state unchanged.
  - Then an=FB, cc=7F held → vld[2]=0, hex[11:8] unchanged, one upd.
- **Errors:**
  - an=DF, cc=55 → err=1, ecode=01, eidx=5, vld[5]=0.
  - Then an=FC → ecode stays 01.
  - Then clr → err=0, ecode=0, vld=0.
- **Full scan:** eight digits 0..7 scanned with 8 cycles per digit → hex=32'h76543210, vld=FF.
